sar_conv_sequencer: RTL and testbench
=====================================

// Module: sar_conv_sequencer
// PURPOSE
//  Initiator side of the SAR digital-controller handshake: drives the controller's
//  i_start, watches o_eoc, captures the o_a2d result. Issues conversions one-shot or
//  at a programmable start-to-start period. Buffers results in a small FIFO with a
//  valid/ready output to downstream logic.
//  Sits between the SAR controller and the sample consumer (DSP/register bank).
// PARAMETERS
//  ADC_RESOLUTION  10  result width; must match the SAR controller
//  PERIOD_W        16  width of i_period
//  FIFO_DEPTH      4   result FIFO entries; power of two, >=2
//  TIMEOUT_CYCLES  64  max cycles from o_start rise to i_eoc rise
//  AVG_LOG2        2   log2 of samples averaged; used only with SEQ_AVG_EN
// PORTS
//  i_clk      in   1               clock
//  i_rst      in   1               reset; synchronous, active-high
//  i_enable   in   1               continuous (periodic) conversion mode
//  i_single   in   1               one-cycle pulse: one conversion; ignored unless IDLE
//  i_period   in   PERIOD_W        start-to-start interval in cycles; latched per launch
//  o_start    out  1               to controller i_start; rising edge launches conversion
//  i_eoc      in   1               from controller o_eoc
//  i_a2d      in   ADC_RESOLUTION  from controller o_a2d
//  o_data     out  ADC_RESOLUTION  FIFO head
//  o_valid    out  1               FIFO non-empty
//  i_ready    in   1               pop when o_valid & i_ready
//  o_busy     out  1               FSM not IDLE
//  o_overflow out  1               sticky: result dropped, FIFO full
//  o_timeout  out  1               sticky: i_eoc not seen in TIMEOUT_CYCLES
//  i_clr_err  in   1               clears both sticky flags next edge
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied; FSM=IDLE; counters, eoc_q 0. i_rst overrides
//   everything mid-conversion. o_start drops on the next edge, no capture.
//  FSM: IDLE -> ARM on i_enable | i_single.
//   ARM (1 cycle): o_start=0, guaranteeing a low phase; period counter cleared.
//   CONV: o_start=1; timeout counter increments.
//    Rising i_eoc (i_eoc & ~eoc_q): capture i_a2d, drop o_start -> GAP.
//    Counter == TIMEOUT_CYCLES-1: drop o_start, set o_timeout, discard -> GAP.
//   GAP: o_start=0. i_enable=1: wait until period counter >= i_period-1, then ARM.
//    i_enable=0 -> IDLE.
//  Period counter runs from ARM entry, saturates at all-ones.
//   i_period 0 or shorter than the conversion: relaunch right after GAP (1 cycle).
//  i_enable drop mid-CONV: conversion completes and is captured, then IDLE.
//   i_single during CONV/GAP: ignored.
//  Capture: FIFO write at the same edge as the eoc-rise detection.
//   o_valid/o_data update the following cycle.
//  FIFO full at capture: sample dropped, o_overflow set. A simultaneous pop frees no
//   space that cycle, so the sample is still dropped.
//  Pop and push in the same cycle on non-empty FIFO: occupancy unchanged, order kept.
//  i_clr_err coincident with a new error event: set wins.
//  o_data is a don't-care when o_valid=0, but must not be X after reset (driven 0).
// CONFIGURATION
//  SEQ_AVG_EN defined:
//   - Accumulator (ADC_RESOLUTION+AVG_LOG2 bits) sums 2**AVG_LOG2 captures.
//   - Each group pushes sum>>AVG_LOG2 (truncate) as one FIFO entry.
//   - Timed-out conversions do not count. Returning to IDLE clears the partial sum.
//   - Overflow is evaluated only at push.
//  SEQ_AVG_EN undefined: every capture pushed directly; AVG_LOG2 unused; no accumulator.
// TESTING
//  1 Reset; i_single pulse; model eoc rise 12 cycles after start rise, a2d=10'h2A5
//    -> one o_valid with o_data=10'h2A5. o_start low >=1 cycle before its rise.
//    o_busy falls after GAP.
//  2 i_enable=1, i_period=40, conv=12 cycles -> o_start rises every 40 cycles.
//    i_period=5 -> rises every 14 cycles (ARM+12+GAP).
//  3 i_ready=0, 5 conversions, FIFO_DEPTH=4 -> 4 entries in order, 5th dropped,
//    o_overflow=1. i_clr_err -> 0. Drain yields first 4 values in order.
//  4 Model never raises eoc -> o_start falls after 64 cycles, o_timeout=1, nothing
//    pushed. Next launch proceeds normally.
//  5 Assert i_rst during CONV -> next edge: o_start=0, o_valid=0, o_busy=0.
//    The late eoc pulse is ignored.
//  6 SEQ_AVG_EN, AVG_LOG2=2, results 100,101,102,104 -> single entry 101; no entry
//    after only 3 conversions.

Source files
------------

// File: rtl/sar_conv_sequencer.sv
// SAR conversion initiator: launches conversions on the controller, captures results into a FIFO.
// Build option SEQ_AVG_EN: each FIFO entry is the truncated mean of 2**AVG_LOG2 captures.
module sar_conv_sequencer #(
  parameter int ADC_RESOLUTION = 10,
  parameter int PERIOD_W       = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int AVG_LOG2       = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_single,
  input  logic [PERIOD_W-1:0]       i_period,
  output logic                      o_start,
  input  logic                      i_eoc,
  input  logic [ADC_RESOLUTION-1:0] i_a2d,
  output logic [ADC_RESOLUTION-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_overflow,
  output logic                      o_timeout,
  input  logic                      i_clr_err
);

  // state | meaning
  // IDLE  | no conversion pending
  // ARM   | one-cycle low phase on o_start, period counter restarts
  // CONV  | o_start high, waiting for eoc rise or timeout
  // GAP   | o_start low, waiting for period expiry or return to IDLE
  // CONV owns a dedicated state bit so o_start decodes from a single flop.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    ARM  = 3'b001,
    GAP  = 3'b010,
    CONV = 3'b100
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t                      state, state_nx;
  logic [PERIOD_W-1:0]         pcnt, period_q;
  logic [TW-1:0]               tcnt;
  logic                        eoc_q;
  logic                        eoc_rise, capture, tmo, period_done;
  logic                        push_req, push, pop, full, empty, ovf_ev;
  logic [ADC_RESOLUTION-1:0]   push_data;
  logic [ADC_RESOLUTION-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]                 wr_ptr, rd_ptr;

  assign eoc_rise    = i_eoc & ~eoc_q;
  assign capture     = (state == CONV) && eoc_rise;
  assign tmo         = (state == CONV) && !eoc_rise && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign period_done = (period_q == '0) || (pcnt >= period_q - PERIOD_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_enable || i_single) state_nx = ARM;
      ARM:     state_nx = CONV;
      CONV:    if (capture || tmo) state_nx = GAP;
      GAP:     if (!i_enable) state_nx = IDLE;
               else if (period_done) state_nx = ARM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_start = (state == CONV);
    o_busy  = (state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      eoc_q    <= 1'b0;
      pcnt     <= '0;
      period_q <= '0;
      tcnt     <= '0;
    end else begin
      eoc_q <= i_eoc;
      if (state_nx == ARM)  pcnt <= '0;
      else if (pcnt != '1)  pcnt <= pcnt + PERIOD_W'(1);
      if (state == ARM) begin
        period_q <= i_period;
        tcnt     <= '0;
      end else if (state == CONV) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

`ifdef SEQ_AVG_EN
  localparam int ACCW = ADC_RESOLUTION + AVG_LOG2;
  logic [ACCW-1:0]     acc, acc_sum;
  logic [AVG_LOG2-1:0] acnt;

  assign acc_sum   = acc + ACCW'(i_a2d);
  assign push_req  = capture && (acnt == '1);
  assign push_data = acc_sum[ACCW-1:AVG_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE) begin
      acc  <= '0;
      acnt <= '0;
    end else if (capture) begin
      if (acnt == '1) begin
        acc  <= '0;
        acnt <= '0;
      end else begin
        acc  <= acc_sum;
        acnt <= acnt + AVG_LOG2'(1);
      end
    end
  end
`else
  logic unused_avg;
  assign unused_avg = ^AVG_LOG2;
  assign push_req   = capture;
  assign push_data  = i_a2d;
`endif

  // Full is judged on current occupancy: a same-cycle pop does not make room.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = push_req && !full;
  assign ovf_ev  = push_req && full;
  assign pop     = !empty && i_ready;
  assign o_valid = !empty;
  assign o_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (ovf_ev)         o_overflow <= 1'b1;
      else if (i_clr_err) o_overflow <= 1'b0;
      if (tmo)            o_timeout  <= 1'b1;
      else if (i_clr_err) o_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for sar_conv_sequencer: behavioural SAR controller model, result scoreboard, monitor.
// Define SEQ_AVG_EN to run the averaging scenario instead of the default scenarios.
module tb_sar_conv_sequencer;
  localparam int RES = 10, PW = 16, DEPTH = 4, TMO = 64;

  logic           clk = 0, rst = 1, enable = 0, single = 0, clr_err = 0;
  logic [PW-1:0]  period = 0;
  logic           o_start, o_valid, o_busy, o_overflow, o_timeout, eoc;
  logic [RES-1:0] a2d = 0, o_data;
  logic           ready, ready_ctl = 1, rand_ready = 0;
  logic           model_eoc = 0, late_eoc = 0;

  assign eoc = model_eoc | late_eoc;

  sar_conv_sequencer #(.ADC_RESOLUTION(RES), .PERIOD_W(PW), .FIFO_DEPTH(DEPTH),
                       .TIMEOUT_CYCLES(TMO), .AVG_LOG2(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_single(single), .i_period(period),
    .o_start(o_start), .i_eoc(eoc), .i_a2d(a2d), .o_data(o_data), .o_valid(o_valid),
    .i_ready(ready), .o_busy(o_busy), .o_overflow(o_overflow), .o_timeout(o_timeout),
    .i_clr_err(clr_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [RES-1:0] sb[$], a2d_q[$];
  int grp[$];
  logic exp_ovf = 0;
  int lat = 12, scnt = 0;
  bit no_eoc = 0, rand_lat = 0;
  int nrises = 0, last_rise = 0, rise_int = 0, hi_len = 0, last_hi = 0;
  int fall_cyc = 0, bfall_cyc = 0, npops = 0;
  logic start_prev = 0, busy_prev = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Expected FIFO contents; a result arriving with DEPTH entries pending is dropped.
  task automatic push_expected(input logic [RES-1:0] v);
    if (sb.size() >= DEPTH) exp_ovf = 1;
    else sb.push_back(v);
  endtask

  task automatic model_capture(input logic [RES-1:0] v);
`ifdef SEQ_AVG_EN
    int s;
    grp.push_back(int'(v));
    if (grp.size() == 4) begin
      s = grp[0] + grp[1] + grp[2] + grp[3];
      push_expected(RES'(s / 4));
      grp.delete();
    end
`else
    push_expected(v);
`endif
  endtask

  always @(posedge clk) begin
    cyc++;
    #2 ready = rand_ready ? 1'($urandom % 2) : ready_ctl;
  end

  // SAR controller: eoc rises after o_start has been seen high for lat cycles.
  always @(posedge clk) begin
    #1;
    if (rst || !o_start) begin
      scnt = 0;
      model_eoc = 0;
      if (rand_lat) lat = $urandom_range(2, 20);
    end else begin
      scnt++;
      if (!no_eoc && scnt == lat && !model_eoc) begin
        a2d = (a2d_q.size() > 0) ? a2d_q.pop_front() : RES'($urandom);
        model_eoc = 1;
        model_capture(a2d);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      start_prev = 0; busy_prev = 0; hi_len = 0;
    end else begin
      if (o_start && !start_prev) begin
        if (nrises > 0) rise_int = cyc - last_rise;
        last_rise = cyc;
        nrises++;
        check("start_low_phase", {31'b0, busy_prev}, 1);
      end
      if (o_start) hi_len++;
      else if (start_prev) begin last_hi = hi_len; hi_len = 0; fall_cyc = cyc; end
      if (!o_busy && busy_prev) bfall_cyc = cyc;
      if (o_valid && ready) begin
        npops++;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_pop: got %0h required no entry", o_data);
        end else check("fifo_data", o_data, sb.pop_front());
      end
      start_prev = o_start; busy_prev = o_busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_single();
    tick(1); single = 1; tick(1); single = 0;
  endtask

  task automatic pulse_clr();
    tick(1); clr_err = 1; tick(1); clr_err = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    tick(2);
    while (o_busy && k < budget) begin @(negedge clk); k++; end
    if (o_busy) check(nm, 32'(o_busy), 0);
    tick(1);
  endtask

  task automatic wait_rises(input int n, input int budget, input string nm);
    int target = nrises + n, k = 0;
    while (nrises < target && k < budget) begin @(negedge clk); k++; end
    if (nrises < target) check(nm, 32'(nrises), 32'(target));
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int k = 0;
    while (o_valid && k < budget) begin @(negedge clk); k++; end
    tick(2);
    check(nm, 32'(sb.size()), 0);
  endtask

  initial begin
    int p0, seen;
    tick(3);
    @(negedge clk);
    check("rst_start", 32'(o_start), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_ovf", 32'(o_overflow), 0);
    check("rst_tmo", 32'(o_timeout), 0);
    check("rst_data", 32'(o_data), 0);
    #1 rst = 0;
    tick(2);
    check("idle_after_rst", 32'(o_busy), 0);

`ifdef SEQ_AVG_EN
    a2d_q = '{10'd100, 10'd101, 10'd102, 10'd104};
    p0 = npops;
    enable = 1; period = 0;
    wait_rises(4, 200, "avg_rises");
    enable = 0;
    wait_idle(100, "avg_idle");
    tick(3);
    check("avg_one_entry", 32'(npops - p0), 1);
    check("avg_sb_empty", 32'(sb.size()), 0);
    grp.delete();
    a2d_q = '{10'd7, 10'd8, 10'd9};
    p0 = npops;
    enable = 1;
    wait_rises(3, 200, "avg3_rises");
    enable = 0;
    wait_idle(100, "avg3_idle");
    grp.delete();
    tick(5);
    check("avg3_no_entry", 32'(npops - p0), 0);
    check("avg_ovf", 32'(o_overflow), 0);
`else
    // one-shot conversion
    a2d_q.push_back(10'h2A5);
    p0 = npops;
    pulse_single();
    wait_idle(100, "t1_idle");
    tick(3);
    check("t1_pops", 32'(npops - p0), 1);
    check("t1_start_len", 32'(last_hi), 12);
    check("t1_busy_fall", 32'(bfall_cyc - fall_cyc), 1);

    // periodic launches
    enable = 1; period = 40;
    wait_rises(3, 400, "t2_rises40");
    check("t2_period40", 32'(rise_int), 40);
    period = 5;
    wait_rises(3, 200, "t2_rises5");
    check("t2_period5", 32'(rise_int), 14);
    enable = 0;
    wait_idle(200, "t2_idle");
    wait_drain(50, "t2_drain");

    // overflow with stalled consumer
    ready_ctl = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_single();
      wait_idle(100, "t3_idle");
      if (i == 3) check("t3_no_ovf_at4", 32'(o_overflow), 0);
    end
    check("t3_ovf", 32'(o_overflow), 32'(exp_ovf));
    check("t3_valid", 32'(o_valid), 1);
    pulse_clr();
    exp_ovf = 0;
    tick(1);
    check("t3_ovf_clr", 32'(o_overflow), 0);
    p0 = npops;
    ready_ctl = 1;
    wait_drain(50, "t3_drain");
    check("t3_pops", 32'(npops - p0), 4);

    // timeout
    no_eoc = 1;
    p0 = npops;
    pulse_single();
    wait_idle(200, "t4_idle");
    check("t4_start_len", 32'(last_hi), TMO);
    check("t4_tmo", 32'(o_timeout), 1);
    check("t4_valid", 32'(o_valid), 0);
    no_eoc = 0;
    pulse_single();
    wait_idle(100, "t4b_idle");
    tick(3);
    check("t4_next_pops", 32'(npops - p0), 1);
    pulse_clr();
    tick(1);
    check("t4_tmo_clr", 32'(o_timeout), 0);

    // reset mid-conversion, one entry parked in the FIFO
    ready_ctl = 0;
    pulse_single();
    wait_idle(100, "t5_idle");
    pulse_single();
    tick(5);
    check("t5_in_conv", 32'(o_start), 1);
    rst = 1;
    tick(1);
    check("t5_start", 32'(o_start), 0);
    check("t5_valid", 32'(o_valid), 0);
    check("t5_busy", 32'(o_busy), 0);
    sb.delete();
    tick(1);
    rst = 0;
    ready_ctl = 1;
    late_eoc = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) late_eoc = 0;
      seen += int'(o_valid) + int'(o_busy);
    end
    check("t5_late_eoc", 32'(seen), 0);

    // randomized periodic run with random latency and back-pressure
    rand_lat = 1; rand_ready = 1; enable = 1;
    for (int s = 0; s < 8; s++) begin
      period = PW'($urandom_range(0, 30));
      wait_rises(3, 400, "rnd_rises");
    end
    enable = 0;
    wait_idle(200, "rnd_idle");
    rand_ready = 0;
    wait_drain(50, "rnd_drain");
    check("rnd_ovf", 32'(o_overflow), 32'(exp_ovf));
    check("rnd_tmo", 32'(o_timeout), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "global timeout");
  end
endmodule
